heap_sift_up: RTL and testbench
===============================

Name: heap_sift_up

Overview:
- Sequential sift-up (heapify-up) engine for the BRAM-backed max-heap; used on insert.
- This is the up-direction partner of the combinational sift-down parent/child comparator.
- Caller places a new element at leaf index N. The engine walks it toward the root using the hole method, one compare per level, through a simple dual-port BRAM interface.
- Storage is 1-based: root at index 1, parent(i) = i >> 1, index 0 unused.

Parameters:
DATA_WIDTH, 32, element width; unsigned compare
ADDR_WIDTH, 10, heap index width; capacity 2**ADDR_WIDTH-1

Ports:
i_clk  input  1  clock; all logic on rising edge
i_rst_n  input  1  asynchronous, active-low reset
i_start  input  1  request; accepted only when o_ready=1
i_index  input  ADDR_WIDTH  hole index of new element (1..2**ADDR_WIDTH-1)
i_data  input  DATA_WIDTH  new element value
o_ready  output  1  idle, can accept i_start
o_done  output  1  one-cycle pulse, coincident with final write
o_final_index  output  ADDR_WIDTH  resting index of new element; valid with o_done, held until next accept
o_mem_rd_en  output  1  BRAM read enable
o_mem_rd_addr  output  ADDR_WIDTH  BRAM read address
i_mem_rd_data  input  DATA_WIDTH  BRAM read data, 1-cycle latency after o_mem_rd_en
o_mem_wr_en  output  1  BRAM write enable
o_mem_wr_addr  output  ADDR_WIDTH  BRAM write address
o_mem_wr_data  output  DATA_WIDTH  BRAM write data

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE; o_ready=1; o_done=0; o_final_index=0.
  - All mem enables 0; addr and data outputs 0.
  - Internal hole h=0, value v=0.
- Reset mid-operation aborts immediately with no further mem traffic. Partially shifted heap contents are the caller's responsibility.
- IDLE:
  - o_ready=1.
  - i_start && i_index!=0: latch v=i_data, h=i_index; go to READ.
  - i_start with i_index==0: ignored; stay IDLE, no mem traffic, no o_done.
- READ:
  - h==1: go to FINAL.
  - Otherwise: rd_en=1, rd_addr=h>>1; go to COMPARE.
- COMPARE (p = i_mem_rd_data):
  - If p < v (strict; ties do not swap):
    - Write mem[h]=p; h <= h>>1.
    - If new h==1: go to FINAL.
    - Else, in the same cycle, rd_en=1, rd_addr=(h>>1)>>1; stay in COMPARE.
  - Else (p >= v): go to FINAL with h unchanged.
  - The overlapped read and write addresses always differ, so there is no BRAM read-during-write hazard.
- FINAL:
  - wr_en=1, mem[h]=v, o_done=1, o_final_index=h; go to IDLE.
- Never more than one read and one write per cycle. o_ready=0 in READ, COMPARE and FINAL; i_start is ignored there.
- Latency, counted from the accept cycle (cycle 0), with k = number of swaps:
  - Stops below the root: FINAL / o_done at cycle k+3.
  - Reaches the root: FINAL / o_done at cycle k+2.
  - i_index==1: o_done at cycle 2.
- Back-to-back operation: a new i_start may be accepted in the cycle after o_done, since IDLE is reached then.
- Width rules:
  - Compare is unsigned over DATA_WIDTH.
  - Shifts are logical; no arithmetic widening is needed.
  - i_index above capacity is unrepresentable by width.

Decomposition:
- Shared package heap_pkg holds:
  - data_t (DATA_WIDTH) and addr_t (ADDR_WIDTH);
  - ROOT_INDEX=1;
  - function parent_idx(addr_t);
  - sift_up_state_e {IDLE, READ, COMPARE, FINAL}.
- No sub-module: the single compare is inline.
- BRAM sits outside the block; the bench uses a 1-cycle-latency simple dual-port model.

Test Plan:
1. Heap[1..7]=90,70,80,30,40,50,60, mem[8]=x; start index=8, data=85 -> writes mem[8]=30, mem[4]=70, then FINAL mem[2]=85; o_final_index=2; o_done at cycle 5; heap property holds.
2. Same heap, data=95 at index 8 -> writes mem[8]=30, mem[4]=70, mem[2]=90, mem[1]=95; o_final_index=1; o_done at cycle 5 (k=3, root case).
3. Tie: data=30 at index 8 (parent 30) -> no swap; single write mem[8]=30; o_final_index=8; o_done at cycle 3.
4. Empty heap, start index=1, data=7 -> no read; mem[1]=7; o_done at cycle 2. Separately, index=0 -> no traffic, o_ready stays 1.
5. Reset mid-op: assert i_rst_n=0 during COMPARE of case 1 -> next edge has o_ready=1, no wr_en, o_done=0; a new start then completes normally.
6. Back-to-back: second start issued the cycle after o_done; i_start pulses during busy are ignored -> exactly two o_done pulses with correct final indices.

Source files
------------

// File: rtl/heap_pkg.sv
// Shared types and helpers for the BRAM-backed max-heap engines.
// Storage is 1-based: root at index 1 and index 0 is never used.
package heap_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 10;
    localparam int unsigned ROOT_INDEX = 1;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        COMPARE = 2'd2,
        FINAL   = 2'd3
    } sift_up_state_e;

    function automatic addr_t parent_idx(input addr_t idx);
        return idx >> 1;
    endfunction

endpackage

// File: rtl/heap_sift_up.sv
// Sift-up engine for the max-heap using the hole method.
// One parent read and at most one shift-down write per level.
module heap_sift_up
    import heap_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = heap_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = heap_pkg::ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_index,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic                  o_done,
    output logic [ADDR_WIDTH-1:0] o_final_index,
    output logic                  o_mem_rd_en,
    output logic [ADDR_WIDTH-1:0] o_mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_mem_rd_data,
    output logic                  o_mem_wr_en,
    output logic [ADDR_WIDTH-1:0] o_mem_wr_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wr_data
);

    localparam logic [ADDR_WIDTH-1:0] ROOT = ADDR_WIDTH'(ROOT_INDEX);

    sift_up_state_e        state_q, state_d;
    logic [ADDR_WIDTH-1:0] h_q, h_d;
    logic [DATA_WIDTH-1:0] v_q, v_d;
    logic [ADDR_WIDTH-1:0] final_q, final_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            h_q     <= '0;
            v_q     <= '0;
            final_q <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            final_q <= final_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        h_d           = h_q;
        v_d           = v_q;
        final_d       = final_q;
        o_ready       = 1'b0;
        o_done        = 1'b0;
        o_mem_rd_en   = 1'b0;
        o_mem_rd_addr = '0;
        o_mem_wr_en   = 1'b0;
        o_mem_wr_addr = '0;
        o_mem_wr_data = '0;

        case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                if (i_start && (i_index != '0)) begin
                    v_d     = i_data;
                    h_d     = i_index;
                    state_d = READ;
                end
            end
            READ: begin
                if (h_q == ROOT) begin
                    state_d = FINAL;
                end else begin
                    o_mem_rd_en   = 1'b1;
                    o_mem_rd_addr = h_q >> 1;
                    state_d       = COMPARE;
                end
            end
            COMPARE: begin
                // Ties stop the walk so equal keys keep their original order.
                if (i_mem_rd_data < v_q) begin
                    o_mem_wr_en   = 1'b1;
                    o_mem_wr_addr = h_q;
                    o_mem_wr_data = i_mem_rd_data;
                    h_d           = h_q >> 1;
                    if (h_d == ROOT) begin
                        state_d = FINAL;
                    end else begin
                        // Next parent read overlaps this write; addresses never collide.
                        o_mem_rd_en   = 1'b1;
                        o_mem_rd_addr = h_d >> 1;
                    end
                end else begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                o_mem_wr_en   = 1'b1;
                o_mem_wr_addr = h_q;
                o_mem_wr_data = v_q;
                o_done        = 1'b1;
                final_d       = h_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_final_index = (state_q == FINAL) ? h_q : final_q;

endmodule

// File: tb/tb_heap_sift_up.sv
// Directed bench for heap_sift_up with a 1-cycle-latency dual-port BRAM model.
module tb_heap_sift_up;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic [9:0]  i_index;
    logic [31:0] i_data;
    logic        o_ready, o_done;
    logic [9:0]  o_final_index;
    logic        rd_en, wr_en;
    logic [9:0]  rd_addr, wr_addr;
    logic [31:0] rd_data, wr_data;

    logic        ld_en;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;
    logic [31:0] mem [0:1023];

    int checks = 0;
    int errors = 0;
    int nrd;
    logic [9:0]  wa_q [$];
    logic [31:0] wd_q [$];
    int lat;
    logic [9:0] fidx;

    always #5 clk = ~clk;

    heap_sift_up #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_index(i_index),
        .i_data(i_data), .o_ready(o_ready), .o_done(o_done),
        .o_final_index(o_final_index), .o_mem_rd_en(rd_en), .o_mem_rd_addr(rd_addr),
        .i_mem_rd_data(rd_data), .o_mem_wr_en(wr_en), .o_mem_wr_addr(wr_addr),
        .o_mem_wr_data(wr_data)
    );

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (wr_en) mem[wr_addr] <= wr_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Heap[1..7] = 90,70,80,30,40,50,60; everything else up to 15 cleared.
    task automatic load_base();
        logic [31:0] base [1:7];
        base = '{90, 70, 80, 30, 40, 50, 60};
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            ld_en   = 1'b1;
            ld_addr = 10'(i);
            ld_data = (i <= 7) ? base[i] : 32'd0;
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic run_op(input logic [9:0] idx, input logic [31:0] d,
                          output int l, output logic [9:0] f);
        nrd = 0;
        wa_q.delete();
        wd_q.delete();
        l = -1;
        f = '0;
        @(negedge clk);
        i_start = 1'b1;
        i_index = idx;
        i_data  = d;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) i_start = 1'b0;
            if (rd_en) nrd++;
            if (wr_en) begin
                wa_q.push_back(wr_addr);
                wd_q.push_back(wr_data);
            end
            if (o_done) begin
                l = n;
                f = o_final_index;
                break;
            end
        end
    endtask

    task automatic chk_wr(input string tag, input int i, input logic [9:0] a, input logic [31:0] d);
        chk({tag, "_addr"}, (i < wa_q.size()) ? 32'(wa_q[i]) : 32'hdead, 32'(a));
        chk({tag, "_data"}, (i < wd_q.size()) ? wd_q[i] : 32'hdead, d);
    endtask

    initial begin
        logic ok;
        int ndone;
        int dcyc [2];
        logic [9:0] dfi [2];
        int busy;

        rst_n   = 1'b0;
        i_start = 1'b0;
        i_index = '0;
        i_data  = '0;
        ld_en   = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(o_ready), 1);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_fidx", 32'(o_final_index), 0);
        chk("rst_rd_en", 32'(rd_en), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_addrs", 32'({rd_addr, wr_addr}), 0);
        chk("rst_wdata", wr_data, 0);
        rst_n = 1'b1;

        // 1: stops below root after two swaps.
        load_base();
        run_op(10'd8, 32'd85, lat, fidx);
        chk("t1_lat", 32'(lat), 5);
        chk("t1_fidx", 32'(fidx), 2);
        chk("t1_nwr", 32'(wa_q.size()), 3);
        chk_wr("t1_w0", 0, 10'd8, 32'd30);
        chk_wr("t1_w1", 1, 10'd4, 32'd70);
        chk_wr("t1_w2", 2, 10'd2, 32'd85);
        @(negedge clk);
        ok = 1'b1;
        for (int i = 2; i <= 8; i++) if (mem[i] > mem[i >> 1]) ok = 1'b0;
        chk("t1_heap", 32'(ok), 1);
        chk("t1_mem2", mem[2], 85);
        repeat (3) @(negedge clk);
        chk("t1_fidx_hold", 32'(o_final_index), 2);
        chk("t1_ready", 32'(o_ready), 1);

        // 2: new maximum walks all the way to the root.
        load_base();
        run_op(10'd8, 32'd95, lat, fidx);
        chk("t2_lat", 32'(lat), 5);
        chk("t2_fidx", 32'(fidx), 1);
        chk("t2_nwr", 32'(wa_q.size()), 4);
        chk_wr("t2_w2", 2, 10'd2, 32'd90);
        chk_wr("t2_w3", 3, 10'd1, 32'd95);

        // 3: tie with parent does not swap.
        load_base();
        run_op(10'd8, 32'd30, lat, fidx);
        chk("t3_lat", 32'(lat), 3);
        chk("t3_fidx", 32'(fidx), 8);
        chk("t3_nwr", 32'(wa_q.size()), 1);
        chk_wr("t3_w0", 0, 10'd8, 32'd30);

        // 4: insert at root, then an index-0 request that must be ignored.
        run_op(10'd1, 32'd7, lat, fidx);
        chk("t4_lat", 32'(lat), 2);
        chk("t4_fidx", 32'(fidx), 1);
        chk("t4_nrd", 32'(nrd), 0);
        @(negedge clk);
        chk("t4_mem1", mem[1], 7);
        i_start = 1'b1;
        i_index = 10'd0;
        i_data  = 32'd123;
        ok = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            i_start = 1'b0;
            if (rd_en || wr_en || o_done || !o_ready) ok = 1'b0;
        end
        chk("t4_idx0_quiet", 32'(ok), 1);

        // 5: asynchronous reset while comparing.
        load_base();
        @(negedge clk);
        i_start = 1'b1;
        i_index = 10'd8;
        i_data  = 32'd85;
        @(negedge clk);
        i_start = 1'b0;
        @(negedge clk);
        chk("t5_in_compare_wr", 32'(wr_en), 1);
        rst_n = 1'b0;
        #1;
        chk("t5_ready", 32'(o_ready), 1);
        chk("t5_quiet", 32'({wr_en, rd_en, o_done}), 0);
        chk("t5_fidx", 32'(o_final_index), 0);
        @(posedge clk);
        #1;
        chk("t5_quiet_edge", 32'({wr_en, rd_en, o_done}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        load_base();
        run_op(10'd8, 32'd85, lat, fidx);
        chk("t5_after_lat", 32'(lat), 5);
        chk("t5_after_fidx", 32'(fidx), 2);

        // 6: back-to-back starts with ignored pulses while busy.
        load_base();
        ndone = 0;
        dcyc  = '{-1, -1};
        dfi   = '{10'd0, 10'd0};
        busy  = 1;
        @(negedge clk);
        i_start = 1'b1;
        i_index = 10'd8;
        i_data  = 32'd85;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) i_start = 1'b0;
            if (n == 2) begin
                i_start = 1'b1;
                i_index = 10'd3;
                i_data  = 32'd1;
            end
            if (n == 4) i_start = 1'b0;
            if (n >= 2 && n <= 4 && o_ready) busy = 0;
            if (n == 6) begin
                i_start = 1'b1;
                i_index = 10'd9;
                i_data  = 32'd75;
            end
            if (n == 7) i_start = 1'b0;
            if (o_done) begin
                if (ndone < 2) begin
                    dcyc[ndone] = n;
                    dfi[ndone]  = o_final_index;
                end
                ndone++;
            end
        end
        chk("t6_busy", 32'(busy), 1);
        chk("t6_ndone", 32'(ndone), 2);
        chk("t6_cyc0", 32'(dcyc[0]), 5);
        chk("t6_fidx0", 32'(dfi[0]), 2);
        chk("t6_cyc1", 32'(dcyc[1]), 10);
        chk("t6_fidx1", 32'(dfi[1]), 4);
        chk("t6_mem4", mem[4], 75);
        chk("t6_mem9", mem[9], 70);
        chk("t6_mem3", mem[3], 80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
